// File: rtl/output_layer_accumulator.sv
// Final fully-connected stage: accumulates 10 signed class scores from a serial
// activation stream, starting from per-class biases, with saturating arithmetic.
module output_layer_accumulator #(
    parameter int NUM_SIZE   = 26,
    parameter int IN_WIDTH   = 8,
    parameter int W_WIDTH    = 8,
    parameter int NUM_INPUTS = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic                    Start,
    input  logic [NUM_SIZE*10-1:0]  Bias,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [IN_WIDTH-1:0]     Act,
    input  logic [W_WIDTH*10-1:0]   Weights,
    output logic [NUM_SIZE*10-1:0]  Num,
    output logic                    OutValid,
    input  logic                    OutAck,
    output logic                    Busy
);
    localparam int LANES   = 10;
    localparam int P_WIDTH = IN_WIDTH + W_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [NUM_SIZE-1:0]   acc     [LANES];
    logic [NUM_SIZE-1:0]   acc_sat [LANES];
    logic [P_WIDTH-1:0]    prod    [LANES];
    logic [NUM_SIZE:0]     sum     [LANES];
    logic                  accept;
    logic                  last;

    assign accept = InValid && (state == ACCUM);
    assign last   = (cnt == CNT_WIDTH'(NUM_INPUTS - 1));

    always_comb begin
        state_nxt = state;
        InReady   = 1'b0;
        OutValid  = 1'b0;
        Busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) state_nxt = ACCUM;
            end
            ACCUM: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (InValid && last) state_nxt = DONE;
            end
            DONE: begin
                OutValid = 1'b1;
                Busy     = 1'b1;
                if (OutAck) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One guard bit above the score width detects overflow of each lane add.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            prod[k] = P_WIDTH'($signed(Act)) * P_WIDTH'($signed(Weights[W_WIDTH*k +: W_WIDTH]));
            sum[k]  = {acc[k][NUM_SIZE-1], acc[k]}
                    + {{(NUM_SIZE+1-P_WIDTH){prod[k][P_WIDTH-1]}}, prod[k]};
            if (sum[k][NUM_SIZE] != sum[k][NUM_SIZE-1])
                acc_sat[k] = sum[k][NUM_SIZE] ? {1'b1, {(NUM_SIZE-1){1'b0}}}
                                              : {1'b0, {(NUM_SIZE-1){1'b1}}};
            else
                acc_sat[k] = sum[k][NUM_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state <= IDLE;
            cnt   <= '0;
            for (int unsigned k = 0; k < LANES; k++) acc[k] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && Start) begin
                cnt <= '0;
                for (int unsigned k = 0; k < LANES; k++)
                    acc[k] <= Bias[NUM_SIZE*k +: NUM_SIZE];
            end else if (accept) begin
                cnt <= cnt + CNT_WIDTH'(1);
                for (int unsigned k = 0; k < LANES; k++) acc[k] <= acc_sat[k];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) Num[NUM_SIZE*k +: NUM_SIZE] = acc[k];
    end

endmodule

// File: doc/output_layer_accumulator.md
Name: output_layer_accumulator

Overview:
- Final fully-connected stage of the classifier. Sits directly upstream of the 10-way argmax stage.
- Consumes a serial stream of hidden-layer activations, each paired with a 10-lane weight word.
- Accumulates 10 signed class scores, starting from per-class biases.
- Presents the scores as one packed bus with a valid/ack handshake, for the argmax stage to pick the winning class.

Parameters:
- NUM_SIZE, 26: width of each signed class score and accumulator.
- IN_WIDTH, 8: width of a signed activation sample.
- W_WIDTH, 8: width of a signed weight.
- NUM_INPUTS, 64: activations per inference (must be ≥1).
- CNT_WIDTH, 7: sample counter width, ≥ clog2(NUM_INPUTS+1).

Ports:
- clk  in  1  rising-edge clock for all state.
- GlobalReset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse; begins an inference (honoured in IDLE only).
- Bias  in  NUM_SIZE*10  signed per-class bias; class k at [NUM_SIZE*k +: NUM_SIZE]; sampled on the accepted Start.
- InValid  in  1  Act/Weights valid this cycle.
- InReady  out  1  block accepts a sample this cycle.
- Act  in  IN_WIDTH  signed activation.
- Weights  in  W_WIDTH*10  signed weights; class k at [W_WIDTH*k +: W_WIDTH].
- Num  out  NUM_SIZE*10  packed signed scores, class k at [NUM_SIZE*k +: NUM_SIZE]; same packing as the argmax stage's input.
- OutValid  out  1  Num holds a completed result.
- OutAck  in  1  consumer has taken the result.
- Busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset values (sampled on a clk edge with GlobalReset=1): state IDLE, all accumulators 0, counter 0, InReady 0, OutValid 0, Busy 0. Reset overrides all other inputs, including mid-ACCUM and mid-DONE; any partial result is discarded.
- IDLE:
  - InReady=0, OutValid=0.
  - Num holds the last completed result, or 0 after reset.
  - On Start=1: acc[k] <= Bias[k] for every k; counter <= 0; next state ACCUM.
- ACCUM:
  - InReady=1; Busy=1.
  - Sample accepted when InValid && InReady. On acceptance:
    - p[k] = Act * W[k], full-precision signed (IN_WIDTH+W_WIDTH bits), sign-extended to NUM_SIZE+1.
    - acc[k] <= sat(acc[k] + p[k]), all 10 lanes in parallel in one cycle.
    - Counter increments.
  - sat clamps to [-2^(NUM_SIZE-1), 2^(NUM_SIZE-1)-1]. Saturation is sticky only through normal arithmetic; there is no flag.
  - InValid=0: nothing changes; no timeout.
  - When the accepted sample is number NUM_INPUTS (counter == NUM_INPUTS-1 at acceptance): next state DONE.
- DONE:
  - OutValid=1; InReady=0; Num = acc, stable.
  - On OutAck=1: OutValid drops the next cycle; state IDLE.
  - OutAck outside DONE is ignored.
- Latency:
  - OutValid rises on the clk edge after the final sample is accepted, i.e. visible one cycle after acceptance.
  - Minimum inference: 1 (Start) + NUM_INPUTS + 1 cycles.
- Num is driven directly from the accumulator registers (registered output, no combinational path from inputs).
- Boundary conditions:
  - Start in ACCUM or DONE: ignored.
  - Start and OutAck in the same cycle in DONE: OutAck taken, Start ignored; a fresh Start is needed in IDLE.
  - InValid during IDLE or DONE: ignored, no accumulation.
  - Bias changes after Start acceptance: no effect.
  - NUM_INPUTS=1: ACCUM lasts exactly one accepted sample.
  - Counter never wraps: a fixed NUM_INPUTS-sample bound drives the exit.

Test Plan:
- Basic: NUM_INPUTS=4, Bias all 0; 4 samples with Act=1 and W[k]=k -> OutValid one cycle after the 4th acceptance; Num[k]=4k; argmax of Num gives index 9.
- Bias and sign: Bias[3]=100, others 0; 4 samples with Act=-2, W[3]=5, others 1 -> Num[3]=60, Num[k≠3]=-8.
- Stalls: InValid toggled 1,0,0,1,1,0,1 -> exactly 4 samples accumulated; result matches the no-stall run; InReady=1 throughout ACCUM.
- Saturation: NUM_SIZE=16, Bias[0]=32700, Act=127, W[0]=127 -> Num[0]=32767. Bias[1]=-32700, W[1]=-128 -> Num[1]=-32768.
- Handshake: OutAck held 0 for 10 cycles -> Num and OutValid stable. Start pulsed in DONE -> ignored. OutAck=1 -> OutValid 0 next cycle, state IDLE, Num retained.
- Reset mid-op: GlobalReset=1 after 2 of 4 samples -> next edge: OutValid=0, Busy=0, Num=0. A new Start then gives a clean result equal to the Basic case.
